// File: rtl/mem_stack_if.sv
// mem_stack_if: access and status bundle between the RAM controller's
// memory-mapped window and one mem_stack instance.
//   master : controller side; drives select/write/clear/dataIn (and errClear)
//   slave  : stack side; drives dataOut/count/empty/full/overflow/underflow
// errClear exists only when MEM_STACK_ERR_EN is defined.
interface mem_stack_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
);
  logic             select;
  logic             write;
  logic             clear;
`ifdef MEM_STACK_ERR_EN
  logic             errClear;
`endif
  logic [WIDTH-1:0] dataIn;
  logic [WIDTH-1:0] dataOut;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

`ifdef MEM_STACK_ERR_EN
  modport master (
    output select, write, clear, errClear, dataIn,
    input  dataOut, count, empty, full, overflow, underflow
  );
  modport slave (
    input  select, write, clear, errClear, dataIn,
    output dataOut, count, empty, full, overflow, underflow
  );
`else
  modport master (
    output select, write, clear, dataIn,
    input  dataOut, count, empty, full, overflow, underflow
  );
  modport slave (
    input  select, write, clear, dataIn,
    output dataOut, count, empty, full, overflow, underflow
  );
`endif
endinterface

// File: rtl/mem_stack.sv
// mem_stack: memory-mapped hardware LIFO. A write strobe to the region pushes
// dataIn, a read strobe pops; dataOut always holds the registered top word
// (0 when empty), so the word read during a pop strobe is the popped one.
// Ports:
//   CLK  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : mem_stack_if.slave (select, write, clear, errClear, dataIn in;
//          dataOut, count, empty, full, overflow, underflow out)
// Optional feature macro: MEM_STACK_ERR_EN -- sticky overflow/underflow flags
// and the errClear input. Without it the flags are tied to 0.
module mem_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input logic        CLK,
  input logic        RST,
  mem_stack_if.slave bus
);
  localparam int unsigned AW = CW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] top;

  logic             do_push, do_pop, push_ok, pop_ok;
  logic             is_empty, is_full;
  logic [CW-1:0]    sp_m2;
  logic [WIDTH-1:0] below;

  always_comb begin
    is_empty = (sp == '0);
    is_full  = (sp == CW'(DEPTH));
    // clear outranks any strobe in the same cycle
    do_push  = bus.select &  bus.write & ~bus.clear;
    do_pop   = bus.select & ~bus.write & ~bus.clear;
    push_ok  = do_push & ~is_full;
    pop_ok   = do_pop  & ~is_empty;
    // word that becomes the new top after a pop; only meaningful when sp >= 1
    sp_m2    = sp - CW'(2);
    below    = (sp == CW'(1)) ? '0 : mem[sp_m2[AW-1:0]];
  end

  // Storage needs no reset: entries at or above sp are never observed.
  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[sp[AW-1:0]] <= bus.dataIn;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp  <= '0;
      top <= '0;
    end else if (bus.clear) begin
      sp  <= '0;
      top <= '0;
    end else if (push_ok) begin
      sp  <= sp + CW'(1);
      top <= bus.dataIn;
    end else if (pop_ok) begin
      sp  <= sp - CW'(1);
      top <= below;
    end
  end

`ifdef MEM_STACK_ERR_EN
  logic ovf_q, unf_q;

  // errClear applies first so a same-cycle error still sets its flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.errClear) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end
      if (do_push && is_full)
        ovf_q <= 1'b1;
      if (do_pop && is_empty)
        unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.dataOut = top;
  assign bus.count   = sp;
  assign bus.empty   = is_empty;
  assign bus.full    = is_full;
endmodule

// File: doc/mem_stack.md
# mem_stack

Memory-mapped hardware LIFO serving the `addrstack` and `userstack` regions of the RAM controller's memory-mapped window (one instance per region). It consumes the controller's memory-side write data and access strobes, and returns the top-of-stack word on the memory read-back mux. A push is a memory write to the region; a pop is a memory read from it. Status flags feed the status register.

## Interface
Parameters:
- `WIDTH`, 16, data word width
- `DEPTH`, 16, number of entries; power of two, ≥2
- `CW`, $clog2(DEPTH)+1, occupancy counter width

Ports (one clock; reset is asynchronous and active-high):
- `CLK` in 1: system clock; all state updates on its rising edge
- `RST` in 1: asynchronous active-high reset
- `select` in 1: single-cycle access strobe for this stack's region
- `write` in 1: qualifies `select`; 1 = push, 0 = pop
- `clear` in 1: synchronous flush
- `errClear` in 1: clears sticky error flags; present only with `MEM_STACK_ERR_EN`
- `dataIn` in WIDTH: push data
- `dataOut` out WIDTH: current top of stack, registered
- `count` out CW: occupancy, 0..DEPTH
- `empty` out 1: `count == 0`
- `full` out 1: `count == DEPTH`
- `overflow` out 1: sticky; push attempted while full
- `underflow` out 1: sticky; pop attempted while empty

## Operation
- Storage: a `DEPTH`-entry register array plus a stack pointer `sp` equal to `count`. `dataOut` is a dedicated register mirroring `array[sp-1]`, or 0 when empty.
- Per-cycle priority: `clear` > (`select`&`write`) push > (`select`&~`write`) pop > idle.
- Push, not full: `array[sp] <= dataIn`, `sp <= sp+1`, `dataOut <= dataIn`.
- Push, full: storage, `sp`, and `dataOut` are unchanged; the word is dropped; `overflow` is set.
- Pop, not empty: `sp <= sp-1`; `dataOut <= array[sp-2]`, or 0 if `sp == 1`. The value the CPU reads in the strobe cycle is the popped word (the pre-edge `dataOut`).
- Pop, empty: no state change; `dataOut` stays 0; `underflow` is set.
- Clear: `sp <= 0`, `dataOut <= 0`. Array contents are not zeroed. Error flags are unaffected.
- `errClear`: clears `overflow` and `underflow`. If a new error occurs in the same cycle, the set wins.
- Arithmetic: `sp` never wraps. It saturates by rule at 0 and at DEPTH. `count` is exactly `sp`.

## Timing
- Reset values: `dataOut=0`, `count=0`, `empty=1`, `full=0`, `overflow=0`, `underflow=0`. Reset asserted mid-sequence discards all contents immediately, without waiting for a clock edge.
- Push/pop latency is 1 cycle. All outputs reflect the operation after the rising edge that samples `select`.
- `empty` and `full` are combinational decodes of the registered `sp`. They are glitch-free relative to `CLK`.
- Back-to-back strobes every cycle are supported, including alternating push/pop at any fill level.
- Push then immediate pop returns the just-pushed word with no bubble.
- `select` held high for N cycles performs N operations. The upstream controller issues one-cycle strobes per access.

## Configuration
- `MEM_STACK_ERR_EN` defined:
  - `overflow`, `underflow`, and `errClear` exist and behave as above.
- Not defined:
  - The `errClear` port is omitted.
  - `overflow` and `underflow` are tied to 0.
  - Push-while-full and pop-while-empty are still silently ignored; data integrity behaviour is identical.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333 -> `count=3`, `dataOut=0x3333`; pops read 0x3333, 0x2222, 0x1111; end state `empty=1`, `dataOut=0`.
- Push DEPTH words 0x0000..0x000F, then push 0xBEEF -> `full=1`, `count=16`, `overflow=1`, top stays 0x000F; 16 pops return 0x000F..0x0000.
- Pop when empty -> `count=0`, `dataOut=0`, `underflow=1`. Then assert `errClear` with a simultaneous empty pop -> `underflow` remains 1. Then `errClear` alone -> `underflow=0`.
- Push 0xA5A5, 0x5A5A; assert `clear` together with a push strobe of 0x1234 -> `count=0`, `dataOut=0`, push discarded.
- Alternating push/pop every cycle from `count=5` for 20 cycles -> `count` toggles 6/5, and each pop returns the word pushed the cycle before.
- Assert `RST` asynchronously between edges at `count=7` -> all outputs reach reset values before the next edge; a subsequent pop sets `underflow`.
